execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
- Iterative RV64M multiply/divide unit inside the execute stage, directly upstream of the memory stage.
- Accepts one M-extension op per request and computes it over multiple cycles, holding the execute stage through `stall_o`.
- On completion, presents the result for capture into the execute result sent downstream.
- Radix-2 design: shift-add for multiply, restoring shift-subtract for divide.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  M-op request; held high while the stage is stalled.
- op_i  input  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; other codes are illegal.
- a_i  input  XLEN  operand rs1.
- b_i  input  XLEN  operand rs2.
- flush_i  input  1  squash the in-flight op.
- stall_o  output  1  execute stage must hold.
- done_o  output  1  result valid this cycle.
- result_o  output  XLEN  result.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, counter=0, internal regs=0, done_o=0, result_o=0.
  - Reset mid-operation abandons the op; no done_o is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If valid_i=1 and flush_i=0: latch op and operands, then go to RUN with counter=0.
  - Special divide cases skip RUN and go straight to DONE with the special result.
  - An illegal op_i goes to DONE with result 0.
- RUN:
  - One iteration per cycle.
  - N=XLEN iterations for 64-bit ops; N=32 for W ops.
  - After iteration N-1, go to DONE.
- DONE:
  - done_o=1 and result_o valid for exactly one cycle, then return to IDLE.
  - valid_i in DONE is ignored; the same instruction is still present and must not restart.
- Latency:
  - Normal op accepted at edge 0 gives done_o high during the cycle after edge N+1.
  - That is 66 cycles of stall for 64-bit ops and 34 for W ops; the special path gives 2 cycles.
- stall_o = (state==IDLE && valid_i && !flush_i) || state==RUN.
  - stall_o is 0 in DONE, so the stage advances on the done_o cycle.
- result_o holds its last value while in IDLE/RUN; downstream must sample only when done_o=1.
- Multiply:
  - Operands are magnitude-converted per signedness (MULH: both signed; MULHSU: a signed, b unsigned; MULHU/MUL: unsigned).
  - Builds a 2*XLEN product, then negates it if the sign flag is set.
  - MUL and MULW return the low half; MULH* return the high half.
  - MULW uses a[31:0]*b[31:0]; result is the low 32 bits sign-extended to 64.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - W ops use the low 32 bits (sign- or zero-extended per op); the 32-bit result is sign-extended to 64 (including DIVUW/REMUW).
- Special cases, detected in IDLE:
  - Divide by zero: quotient = all ones (−1), remainder = dividend.
  - W variants: dividend is the low 32 bits, sign-extended.
  - Signed overflow (DIV: a=0x8000000000000000, b=−1): quotient = a, remainder = 0.
  - DIVW/REMW overflow with a[31:0]=0x80000000 and b[31:0]=0xFFFFFFFF: quotient = 0xFFFFFFFF80000000, remainder = 0.
- flush_i:
  - In any state, flush_i=1 moves to IDLE next cycle, done_o=0, and the result is discarded.
  - flush_i has priority over valid_i.
  - flush_i in the DONE cycle suppresses nothing already driven that cycle; the pipeline flush logic discards it.
- Back-to-back ops: the next op may be accepted in the IDLE cycle immediately after DONE.

Test Plan:
- MUL a=7, b=−3 (0xFFFFFFFFFFFFFFFD) -> after 66 stall cycles, done_o=1, result=0xFFFFFFFFFFFFFFEB (−21).
- MULHU a=b=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE; MULH with the same operands -> 0.
- DIV a=−20, b=6 -> −3 (0xFFFFFFFFFFFFFFFD); REM with the same operands -> −2; DIVU a=20, b=6 -> 3 in 66 cycles.
- DIVU a=5, b=0 -> 2-cycle latency, result=0xFFFFFFFFFFFFFFFF; REM a=5, b=0 -> 5; DIV a=0x8000000000000000, b=−1 -> 0x8000000000000000.
- DIVW a=0x00000000FFFFFFF8 (−8 in 32 bits), b=2 -> 34-cycle latency, result=0xFFFFFFFFFFFFFFFC; MULW a=0x10000, b=0x10000 -> 0.
- Start DIV, assert flush_i at RUN cycle 10 -> IDLE next cycle, no done_o; new MUL 3×4 issued the following cycle -> result 12. Same sequence with reset instead of flush -> identical recovery and result_o=0 after reset.

Source files
------------

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative radix-2 RV64M multiply/divide unit that holds the execute stage until done
module execute_muldiv #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, n;
  logic mul_q, rem_q, w_q, low_q, neg_q;
  logic [2*XLEN-1:0] acc, x, prod;
  logic [XLEN-1:0] y, opa, opb, ma, mb, dz_rem, spec_res, mul_res, qr, dv, div_res, fin;
  logic [XLEN:0] r_sh, diff;
  logic legal, is_w, is_mul, is_rem, sa, sb, neg_a, neg_b, div_zero, ovf, special, start;
  assign legal    = op_i <= 4'd12;
  assign is_w     = op_i[3];
  assign is_mul   = op_i < 4'd4 || op_i == 4'd8;
  assign is_rem   = op_i inside {4'd6, 4'd7, 4'd11, 4'd12};
  assign sa       = op_i inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
  assign sb       = op_i inside {4'd1, 4'd4, 4'd6, 4'd9, 4'd11};
  assign opa      = is_w ? {{(XLEN-32){sa & a_i[31]}}, a_i[31:0]} : a_i;
  assign opb      = is_w ? {{(XLEN-32){sb & b_i[31]}}, b_i[31:0]} : b_i;
  assign neg_a    = sa & opa[XLEN-1];
  assign neg_b    = sb & opb[XLEN-1];
  assign ma       = neg_a ? -opa : opa;
  assign mb       = neg_b ? -opb : opb;
  assign div_zero = !is_mul && opb == '0;
  assign ovf      = !is_mul && sa && (is_w ? (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == 32'hFFFF_FFFF)
                                           : (a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1));
  assign special  = !legal || div_zero || ovf;
  assign dz_rem   = is_w ? {{(XLEN-32){a_i[31]}}, a_i[31:0]} : a_i;
  assign spec_res = !legal ? '0 : div_zero ? (is_rem ? dz_rem : '1) : (is_rem ? '0 : opa);
  assign start    = state == IDLE && valid_i && !flush_i;
  assign n        = w_q ? CNT_W'(32) : CNT_W'(XLEN);
  assign r_sh     = {acc[XLEN-1:0], y[XLEN-1]};
  assign diff     = r_sh - {1'b0, x[XLEN-1:0]};
  assign prod     = neg_q ? -acc : acc;
  assign mul_res  = low_q ? (w_q ? {{(XLEN-32){prod[31]}}, prod[31:0]} : prod[XLEN-1:0]) : prod[2*XLEN-1:XLEN];
  assign qr       = rem_q ? acc[XLEN-1:0] : y;
  assign dv       = neg_q ? -qr : qr;
  assign div_res  = w_q ? {{(XLEN-32){dv[31]}}, dv[31:0]} : dv;
  assign fin      = mul_q ? mul_res : div_res;
  assign stall_o  = start || state == RUN;
  assign done_o   = state == DONE;
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: flush wins, RUN spends one extra cycle after the last iteration to sign-fix the result
  always_comb begin
    state_n = state;
    state_n = flush_i ? IDLE
            : state == IDLE ? (valid_i ? (special ? DONE : RUN) : IDLE)
            : state == RUN  ? (cnt == n ? DONE : RUN)
            : IDLE;
  end
  // datapath: latch magnitudes on accept, then one shift-add or restoring step per RUN cycle
  always_ff @(posedge clk)
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      x        <= '0;
      y        <= '0;
      mul_q    <= 1'b0;
      rem_q    <= 1'b0;
      w_q      <= 1'b0;
      low_q    <= 1'b0;
      neg_q    <= 1'b0;
      result_o <= '0;
    end else if (start) begin
      cnt   <= '0;
      acc   <= '0;
      mul_q <= is_mul;
      rem_q <= is_rem;
      w_q   <= is_w;
      low_q <= op_i == 4'd0 || op_i == 4'd8;
      neg_q <= (is_mul || !is_rem) ? neg_a ^ neg_b : neg_a;
      x     <= {{XLEN{1'b0}}, is_mul ? ma : mb};
      y     <= is_mul ? mb : (is_w ? {ma[31:0], {(XLEN-32){1'b0}}} : ma);
      if (special) result_o <= spec_res;
    end else if (state == RUN && !flush_i) begin
      cnt <= cnt + 1'b1;
      if (cnt == n) result_o <= fin;
      else if (mul_q) begin
        acc <= y[0] ? acc + x : acc;
        x   <= x << 1;
        y   <= y >> 1;
      end else begin
        acc[XLEN-1:0] <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
        y             <= {y[XLEN-2:0], !diff[XLEN]};
      end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: directed checks of latency, results, special cases, flush and reset recovery
module tb_execute_muldiv;
  logic        clk = 0;
  logic        reset = 1;
  logic        valid_i = 0;
  logic [3:0]  op_i = 0;
  logic [63:0] a_i = 0;
  logic [63:0] b_i = 0;
  logic        flush_i = 0;
  logic        stall_o, done_o;
  logic [63:0] result_o;
  int checks = 0;
  int errors = 0;

  execute_muldiv dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  // drive one op from an IDLE cycle, hold valid until done, return result and number of stalled cycles
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int stalls);
    bit got = 0;
    op_i = op; a_i = a; b_i = b; valid_i = 1; stalls = 0; res = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done_o) begin got = 1; res = result_o; end
      else if (stall_o) stalls++;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL timeout op=%0d no done_o within 200 cycles", op); end
    @(posedge clk); #1 valid_i = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [63:0] r; int s;
    issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_7x-3 got=%h exp=ffffffffffffffeb", r); end
    checks++; if (s !== 66) begin errors++; $display("FAIL mul_latency got=%0d exp=66", s); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", done_o); end
    @(posedge clk); #1;
    issue(4'd3, '1, '1, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulhu_ones got=%h exp=fffffffffffffffe", r); end
    issue(4'd1, '1, '1, r, s);
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL mulh_ones got=%h exp=0", r); end
    issue(4'd2, '1, 64'd2, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_-1x2 got=%h exp=ffffffffffffffff", r); end
  endtask

  task automatic test_div();
    logic [63:0] r; int s;
    issue(4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_-20/6 got=%h exp=fffffffffffffffd", r); end
    issue(4'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_-20%%6 got=%h exp=fffffffffffffffe", r); end
    issue(4'd5, 64'd20, 64'd6, r, s);
    checks++; if (r !== 64'd3) begin errors++; $display("FAIL divu_20/6 got=%h exp=3", r); end
    checks++; if (s !== 66) begin errors++; $display("FAIL divu_latency got=%0d exp=66", s); end
    issue(4'd7, 64'd20, 64'd6, r, s);
    checks++; if (r !== 64'd2) begin errors++; $display("FAIL remu_20%%6 got=%h exp=2", r); end
  endtask

  task automatic test_special();
    logic [63:0] r; int s;
    issue(4'd5, 64'd5, 64'd0, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_by0 got=%h exp=ffffffffffffffff", r); end
    checks++; if (s !== 1) begin errors++; $display("FAIL special_latency got=%0d stalls exp=1", s); end
    issue(4'd6, 64'd5, 64'd0, r, s);
    checks++; if (r !== 64'd5) begin errors++; $display("FAIL rem_by0 got=%h exp=5", r); end
    issue(4'd4, 64'h8000_0000_0000_0000, '1, r, s);
    checks++; if (r !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL div_ovf got=%h exp=8000000000000000", r); end
    checks++; if (s !== 1) begin errors++; $display("FAIL div_ovf_latency got=%0d exp=1", s); end
    issue(4'd6, 64'h8000_0000_0000_0000, '1, r, s);
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL rem_ovf got=%h exp=0", r); end
    issue(4'd9, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL divw_ovf got=%h exp=ffffffff80000000", r); end
    issue(4'd12, 64'h0000_0000_8000_0001, 64'h0, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL remuw_by0 got=%h exp=ffffffff80000001", r); end
    issue(4'd13, 64'd9, 64'd9, r, s);
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL illegal_op got=%h exp=0", r); end
  endtask

  task automatic test_word();
    logic [63:0] r; int s;
    issue(4'd9, 64'h0000_0000_FFFF_FFF8, 64'd2, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL divw_-8/2 got=%h exp=fffffffffffffffc", r); end
    checks++; if (s !== 34) begin errors++; $display("FAIL divw_latency got=%0d exp=34", s); end
    issue(4'd8, 64'h1_0000, 64'h1_0000, r, s);
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL mulw_wrap got=%h exp=0", r); end
    issue(4'd8, 64'h7FFF_FFFF, 64'd2, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulw_sext got=%h exp=fffffffffffffffe", r); end
    issue(4'd10, 64'h0000_0000_FFFF_FFF8, 64'd2, r, s);
    checks++; if (r !== 64'h0000_0000_7FFF_FFFC) begin errors++; $display("FAIL divuw got=%h exp=7ffffffc", r); end
    issue(4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2, r, s);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL remw_-7%%2 got=%h exp=ffffffffffffffff", r); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2; int s1, s2;
    issue(4'd3, 64'd6, 64'd7, r1, s1);
    issue(4'd0, 64'd6, 64'd7, r2, s2);
    checks++; if (r1 !== 64'h0) begin errors++; $display("FAIL b2b_first got=%h exp=0", r1); end
    checks++; if (r2 !== 64'd42) begin errors++; $display("FAIL b2b_second got=%h exp=2a", r2); end
    checks++; if (s2 !== 66) begin errors++; $display("FAIL b2b_latency got=%0d exp=66", s2); end
  endtask

  // abort a DIV at RUN cycle 10 with flush (use_reset=0) or reset (use_reset=1), then run MUL 3x4
  task automatic test_abort(input bit use_reset);
    logic [63:0] r; int s;
    op_i = 4'd4; a_i = 64'hFFFF_FFFF_FFFF_FFEC; b_i = 64'd6; valid_i = 1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    if (use_reset) reset = 1; else flush_i = 1;
    @(posedge clk); #1;
    reset = 0; flush_i = 0; valid_i = 0;
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL abort%0d_done got=%b exp=0", use_reset, done_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL abort%0d_idle got=%b exp=0", use_reset, stall_o); end
    if (use_reset) begin
      checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL abort_reset_result got=%h exp=0", result_o); end
    end
    @(posedge clk); #1;
    issue(4'd0, 64'd3, 64'd4, r, s);
    checks++; if (r !== 64'd12) begin errors++; $display("FAIL abort%0d_mul got=%h exp=c", use_reset, r); end
    checks++; if (s !== 66) begin errors++; $display("FAIL abort%0d_latency got=%0d exp=66", use_reset, s); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_word();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
